// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one combinational 32-bit ALU between two requesters.
// Latches the winning operands, sequences multi-cycle shifts, returns a registered result.
module alu_share_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ReqValid,
    output logic [1:0]       ReqReady,
    input  logic [WIDTH-1:0] ReqA0,
    input  logic [WIDTH-1:0] ReqA1,
    input  logic [WIDTH-1:0] ReqB0,
    input  logic [WIDTH-1:0] ReqB1,
    input  logic [3:0]       ReqSel0,
    input  logic [3:0]       ReqSel1,
    input  logic [CNTW-1:0]  ReqShamt0,
    input  logic [CNTW-1:0]  ReqShamt1,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    output logic [3:0]       AluSel,
    input  logic [WIDTH-1:0] AluResult,
    output logic [1:0]       RspValid,
    output logic [WIDTH-1:0] RspData,
    output logic             Busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] OP_SHL  = 4'b1001;
    localparam logic [3:0] OP_PASS = 4'b1011;

    state_t           state, state_n;
    logic             last_grant;
    logic             id_q;
    logic [WIDTH-1:0] a_q, b_q, work_q;
    logic [3:0]       sel_q;
    logic [CNTW-1:0]  cnt_q;

    logic [1:0]       grant;
    logic             grant_id;
    logic [WIDTH-1:0] a_in, b_in;
    logic [3:0]       sel_in, sel_lat;
    logic [CNTW-1:0]  shamt_in;

    always_comb begin
        grant = 2'b00;
        case (ReqValid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign grant_id = grant[1];
    assign a_in     = grant_id ? ReqA1 : ReqA0;
    assign b_in     = grant_id ? ReqB1 : ReqB0;
    assign sel_in   = grant_id ? ReqSel1 : ReqSel0;
    assign shamt_in = grant_id ? ReqShamt1 : ReqShamt0;

    // Opcode 0000 would make the ALU hold, and a zero-length shift is just A:
    // both are folded into pass-A at latch time so EXEC sees only real shifts.
    always_comb begin
        sel_lat = sel_in;
        if (sel_in == 4'b0000 || (sel_in == OP_SHL && shamt_in == '0))
            sel_lat = OP_PASS;
    end

    always_comb begin
        state_n  = state;
        AluA     = '0;
        AluB     = '0;
        AluSel   = OP_PASS;
        ReqReady = 2'b00;
        RspValid = 2'b00;
        Busy     = 1'b1;
        case (state)
            IDLE: begin
                Busy     = 1'b0;
                ReqReady = grant;
                if (|grant) state_n = EXEC;
            end
            EXEC: begin
                AluB = b_q;
                if (sel_q == OP_SHL) begin
                    AluA   = work_q;
                    AluSel = OP_SHL;
                    if (cnt_q == CNTW'(1)) state_n = DONE;
                end else begin
                    AluA    = a_q;
                    AluSel  = sel_q;
                    state_n = DONE;
                end
            end
            DONE: begin
                RspValid = id_q ? 2'b10 : 2'b01;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            work_q     <= '0;
            sel_q      <= OP_PASS;
            cnt_q      <= '0;
            RspData    <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (|grant) begin
                    a_q        <= a_in;
                    b_q        <= b_in;
                    work_q     <= a_in;
                    sel_q      <= sel_lat;
                    cnt_q      <= shamt_in;
                    id_q       <= grant_id;
                    last_grant <= grant_id;
                end
                EXEC: begin
                    work_q <= AluResult;
                    cnt_q  <= cnt_q - CNTW'(1);
                    if (state_n == DONE) RspData <= AluResult;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: behavioural ALU plus a reference
// model computing results directly (shift by N as a single << N).
module tb_alu_share_ctrl;
    localparam int W  = 32;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    ReqValid, ReqReady, RspValid;
    logic [W-1:0]  ReqA0, ReqA1, ReqB0, ReqB1, AluA, AluB, AluResult, RspData;
    logic [3:0]    ReqSel0, ReqSel1, AluSel;
    logic [CW-1:0] ReqShamt0, ReqShamt1;
    logic          Busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic sel0_seen = 1'b0;

    alu_share_ctrl #(.WIDTH(W), .CNTW(CW)) dut (
        .clk(clk), .rst(rst), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqA0(ReqA0), .ReqA1(ReqA1), .ReqB0(ReqB0), .ReqB1(ReqB1),
        .ReqSel0(ReqSel0), .ReqSel1(ReqSel1), .ReqShamt0(ReqShamt0), .ReqShamt1(ReqShamt1),
        .AluA(AluA), .AluB(AluB), .AluSel(AluSel), .AluResult(AluResult),
        .RspValid(RspValid), .RspData(RspData), .Busy(Busy)
    );

    always #5 clk = ~clk;

    // Combinational ALU the controller is meant to drive
    always_comb begin
        case (AluSel)
            4'b0010: AluResult = AluA - AluB;
            4'b0101: AluResult = AluA & AluB;
            4'b0110: AluResult = AluA | AluB;
            4'b0111: AluResult = ~AluA;
            4'b1000: AluResult = AluA ^ AluB;
            4'b1001: AluResult = AluA << 1;
            4'b1011: AluResult = AluA;
            default: AluResult = AluA + AluB;
        endcase
    end

    always @(negedge clk) if (rst === 1'b0 && AluSel === 4'b0000) sel0_seen = 1'b1;

    function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [3:0] sel, input int shamt);
        case (sel)
            4'b0000: return a;
            4'b0010: return a - b;
            4'b0101: return a & b;
            4'b0110: return a | b;
            4'b0111: return ~a;
            4'b1000: return a ^ b;
            4'b1001: return (shamt >= W) ? '0 : (a << shamt);
            4'b1011: return a;
            default: return a + b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] sel, input int shamt);
        return (sel == 4'b1001 && shamt != 0) ? shamt + 1 : 2;
    endfunction

    task automatic drive_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [3:0] sel, input int shamt);
        if (r == 0) begin
            ReqA0 = a; ReqB0 = b; ReqSel0 = sel; ReqShamt0 = CW'(shamt); ReqValid[0] = 1'b1;
        end else begin
            ReqA1 = a; ReqB1 = b; ReqSel1 = sel; ReqShamt1 = CW'(shamt); ReqValid[1] = 1'b1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; ReqValid = 2'b00;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    endtask

    // Waits (bounded) for a response, starting before the first post-accept negedge.
    task automatic wait_rsp(input int budget, output int cyc, output logic [1:0] v,
                            output logic [W-1:0] d, output int shl_n, output int pex_n);
        cyc = -1; v = 2'b00; d = '0; shl_n = 0; pex_n = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (AluSel === 4'b1001) shl_n++;
            if (Busy === 1'b1 && RspValid === 2'b00 && AluSel === 4'b1011) pex_n++;
            if (RspValid !== 2'b00) begin cyc = k; v = RspValid; d = RspData; break; end
        end
    endtask

    task automatic test_reset();
        ReqValid = 2'b00; ReqA0 = '0; ReqA1 = '0; ReqB0 = '0; ReqB1 = '0;
        ReqSel0 = 4'b0001; ReqSel1 = 4'b0001; ReqShamt0 = '0; ReqShamt1 = '0;
        apply_reset();
        @(negedge clk);
        total_cnt++; if (RspValid !== 2'b00) $display("FAIL reset_rspvalid got %b want 00", RspValid); else pass_cnt++;
        total_cnt++; if (RspData !== '0) $display("FAIL reset_rspdata got %h want 0", RspData); else pass_cnt++;
        total_cnt++; if (AluA !== '0 || AluB !== '0) $display("FAIL reset_aluab got %h/%h want 0/0", AluA, AluB); else pass_cnt++;
        total_cnt++; if (AluSel !== 4'b1011) $display("FAIL reset_alusel got %b want 1011", AluSel); else pass_cnt++;
        total_cnt++; if (Busy !== 1'b0 || ReqReady !== 2'b00) $display("FAIL reset_busy_ready got %b/%b want 0/00", Busy, ReqReady); else pass_cnt++;
    endtask

    task automatic test_single_add();
        int cyc, sn, pn; logic [1:0] v; logic [W-1:0] d;
        @(negedge clk);
        drive_req(0, 32'd5, 32'd7, 4'b0001, 0);
        #1;
        total_cnt++; if (ReqReady !== 2'b01) $display("FAIL add_ready got %b want 01", ReqReady); else pass_cnt++;
        @(posedge clk); #1 ReqValid = 2'b00;
        wait_rsp(20, cyc, v, d, sn, pn);
        total_cnt++; if (cyc !== 2 || v !== 2'b01) $display("FAIL add_rsp got cyc=%0d v=%b want cyc=2 v=01", cyc, v); else pass_cnt++;
        total_cnt++; if (d !== 32'd12) $display("FAIL add_data got %0d want 12", d); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        int cyc, sn, pn; logic [1:0] v; logic [W-1:0] d;
        apply_reset();
        @(negedge clk);
        drive_req(0, 32'd10, 32'd3, 4'b0010, 0);
        drive_req(1, 32'hF0, 32'h0F, 4'b1000, 0);
        #1;
        total_cnt++; if (ReqReady !== 2'b01) $display("FAIL sim_ready0 got %b want 01", ReqReady); else pass_cnt++;
        @(posedge clk); #1 ReqValid[0] = 1'b0;
        wait_rsp(20, cyc, v, d, sn, pn);
        total_cnt++; if (cyc !== 2 || v !== 2'b01 || d !== 32'd7) $display("FAIL sim_rsp0 got cyc=%0d v=%b d=%h want 2/01/7", cyc, v, d); else pass_cnt++;
        total_cnt++; if (ReqReady !== 2'b00) $display("FAIL sim_done_noready got %b want 00", ReqReady); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (ReqReady !== 2'b10) $display("FAIL sim_ready1 got %b want 10", ReqReady); else pass_cnt++;
        @(posedge clk); #1 ReqValid[1] = 1'b0;
        wait_rsp(20, cyc, v, d, sn, pn);
        total_cnt++; if (cyc !== 2 || v !== 2'b10 || d !== 32'hFF) $display("FAIL sim_rsp1 got cyc=%0d v=%b d=%h want 2/10/ff", cyc, v, d); else pass_cnt++;
    endtask

    task automatic test_shift();
        int cyc, sn, pn; logic [1:0] v; logic [W-1:0] d;
        @(negedge clk);
        drive_req(1, 32'd1, 32'd0, 4'b1001, 5);
        #1;
        total_cnt++; if (ReqReady !== 2'b10) $display("FAIL shl5_ready got %b want 10", ReqReady); else pass_cnt++;
        @(posedge clk); #1 ReqValid = 2'b00;
        wait_rsp(40, cyc, v, d, sn, pn);
        total_cnt++; if (sn !== 5) $display("FAIL shl5_selcycles got %0d want 5", sn); else pass_cnt++;
        total_cnt++; if (cyc !== 6 || v !== 2'b10 || d !== 32'd32) $display("FAIL shl5_rsp got cyc=%0d v=%b d=%h want 6/10/20", cyc, v, d); else pass_cnt++;
        @(negedge clk);
        drive_req(0, 32'd3, 32'd9, 4'b1001, 31);
        @(posedge clk); #1 ReqValid = 2'b00;
        wait_rsp(60, cyc, v, d, sn, pn);
        total_cnt++; if (cyc !== 32 || v !== 2'b01 || d !== 32'h8000_0000) $display("FAIL shl31_rsp got cyc=%0d v=%b d=%h want 32/01/80000000", cyc, v, d); else pass_cnt++;
    endtask

    task automatic test_shift_zero();
        int cyc, sn, pn; logic [1:0] v; logic [W-1:0] d;
        @(negedge clk);
        drive_req(0, 32'hDEAD, 32'h1, 4'b1001, 0);
        @(posedge clk); #1 ReqValid = 2'b00;
        wait_rsp(20, cyc, v, d, sn, pn);
        total_cnt++; if (sn !== 0 || pn !== 1) $display("FAIL shl0_sel got shl=%0d pass=%0d want 0/1", sn, pn); else pass_cnt++;
        total_cnt++; if (cyc !== 2 || d !== 32'hDEAD) $display("FAIL shl0_rsp got cyc=%0d d=%h want 2/dead", cyc, d); else pass_cnt++;
    endtask

    task automatic test_op_zero();
        int cyc, sn, pn; logic [1:0] v; logic [W-1:0] d;
        sel0_seen = 1'b0;
        @(negedge clk);
        drive_req(0, 32'h1234, 32'h5555, 4'b0000, 0);
        @(posedge clk); #1 ReqValid = 2'b00;
        wait_rsp(20, cyc, v, d, sn, pn);
        total_cnt++; if (sel0_seen !== 1'b0) $display("FAIL op0_sel got sel0_seen=%b want 0", sel0_seen); else pass_cnt++;
        total_cnt++; if (cyc !== 2 || d !== 32'h1234) $display("FAIL op0_rsp got cyc=%0d d=%h want 2/1234", cyc, d); else pass_cnt++;
    endtask

    task automatic test_reset_mid_shift();
        int cyc, sn, pn, spurious; logic [1:0] v; logic [W-1:0] d;
        spurious = 0;
        @(negedge clk);
        drive_req(0, 32'h7, 32'h0, 4'b1001, 10);
        @(posedge clk); #1 ReqValid = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (RspValid !== 2'b00) spurious++;
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (RspValid !== 2'b00 || RspData !== '0 || AluA !== '0 || AluB !== '0 || AluSel !== 4'b1011 || Busy !== 1'b0)
            $display("FAIL rstmid_outputs got v=%b d=%h a=%h b=%h sel=%b busy=%b want 00/0/0/0/1011/0",
                     RspValid, RspData, AluA, AluB, AluSel, Busy);
        else pass_cnt++;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (RspValid !== 2'b00) spurious++;
        end
        total_cnt++; if (spurious !== 0) $display("FAIL rstmid_norsp got %0d pulses want 0", spurious); else pass_cnt++;
        drive_req(0, 32'd100, 32'd23, 4'b0001, 0);
        #1;
        total_cnt++; if (ReqReady !== 2'b01) $display("FAIL rstmid_ready got %b want 01", ReqReady); else pass_cnt++;
        @(posedge clk); #1 ReqValid = 2'b00;
        wait_rsp(20, cyc, v, d, sn, pn);
        total_cnt++; if (cyc !== 2 || v !== 2'b01 || d !== 32'd123) $display("FAIL rstmid_rsp got cyc=%0d v=%b d=%0d want 2/01/123", cyc, v, d); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [3:0] ops [12] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'h3, 4'hC, 4'hF};
        logic [W-1:0] pa [2], pb [2];
        logic [3:0]   ps [2];
        int           pn_sh [2];
        bit           pend [2];
        int g, cyc, sn, pn, model_last;
        logic [1:0] v; logic [W-1:0] d, exp_d;
        apply_reset();
        model_last = 1; pend[0] = 0; pend[1] = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(0, 3) != 0 || (r == 1 && !pend[0]))) begin
                    pa[r] = $urandom; pb[r] = $urandom;
                    ps[r] = ops[$urandom_range(0, 11)];
                    pn_sh[r] = $urandom_range(0, 31);
                    pend[r] = 1;
                    drive_req(r, pa[r], pb[r], ps[r], pn_sh[r]);
                end
            end
            #1;
            g = (pend[0] && pend[1]) ? (model_last == 1 ? 0 : 1) : (pend[0] ? 0 : 1);
            total_cnt++; if (ReqReady !== (2'b01 << g)) $display("FAIL rnd_ready[%0d] got %b want %b", n, ReqReady, 2'b01 << g); else pass_cnt++;
            @(posedge clk); #1 ReqValid[g] = 1'b0;
            pend[g] = 0; model_last = g;
            exp_d = ref_result(pa[g], pb[g], ps[g], pn_sh[g]);
            wait_rsp(60, cyc, v, d, sn, pn);
            total_cnt++;
            if (cyc !== ref_lat(ps[g], pn_sh[g]) || v !== (2'b01 << g) || d !== exp_d)
                $display("FAIL rnd_rsp[%0d] sel=%b n=%0d got cyc=%0d v=%b d=%h want cyc=%0d v=%b d=%h",
                         n, ps[g], pn_sh[g], cyc, v, d, ref_lat(ps[g], pn_sh[g]), 2'b01 << g, exp_d);
            else pass_cnt++;
            total_cnt++; if (ReqReady !== 2'b00) $display("FAIL rnd_done_ready[%0d] got %b want 00", n, ReqReady); else pass_cnt++;
        end
        ReqValid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_simultaneous();
        test_shift();
        test_shift_zero();
        test_op_zero();
        test_reset_mid_shift();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
